// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the multi-channel tick generator.
// Default divisors assume a 50 MHz system clock.
package tick_gen_pkg;

    localparam int unsigned CLK_HZ    = 50_000_000;
    localparam int unsigned DIV_1HZ   = CLK_HZ;
    localparam int unsigned DIV_1KHZ  = CLK_HZ / 1000;
    localparam int unsigned DEF_CNT_W = 26;

    // Width of a channel-select field; never narrower than one bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: wrapping counter, active divisor, registered tick and square wave.
// The divisor is replaced through load, which also restarts the period at count 0.
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int unsigned        CNT_W   = DEF_CNT_W,
    parameter logic [CNT_W-1:0]   DIV_RST = CNT_W'(DIV_1KHZ)
) (
    input  logic             clk_50MHz,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    output logic             wrap_c,
    output logic             idle_c,
    output logic             tick,
    output logic             sq
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;

    // A zero divisor parks the channel just like a cleared enable.
    assign idle_c = !en || (div == '0);
    assign wrap_c = !idle_c && (cnt == div - CNT_W'(1));

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            div  <= DIV_RST;
            tick <= 1'b0;
            sq   <= 1'b0;
        end else if (sync_clr) begin
            cnt  <= '0;
            tick <= 1'b0;
            sq   <= 1'b0;
            if (load) begin
                div <= load_div;
            end
        end else if (load) begin
            // Loads land on a wrap or while idle, so the period in flight completes intact.
            div  <= load_div;
            cnt  <= '0;
            tick <= wrap_c;
            sq   <= sq ^ wrap_c;
        end else if (wrap_c) begin
            cnt  <= '0;
            tick <= 1'b1;
            sq   <= ~sq;
        end else begin
            tick <= 1'b0;
            if (!idle_c) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tick_generator.sv
// Multi-channel tick generator with a single shared divisor-update slot.
// The slot drains into its target channel at that channel's next wrap, or at once if idle.
module tick_generator
    import tick_gen_pkg::*;
#(
    parameter int unsigned               NUM_CH   = 2,
    parameter int unsigned               CNT_W    = DEF_CNT_W,
    parameter logic [NUM_CH*CNT_W-1:0]   DIV_INIT = {CNT_W'(DIV_1HZ), CNT_W'(DIV_1KHZ)}
) (
    input  logic                        clk_50MHz,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           en,
    input  logic                        sync_clr,
    input  logic                        cfg_valid,
    input  logic [sel_w(NUM_CH)-1:0]    cfg_ch,
    input  logic [CNT_W-1:0]            cfg_div,
    output logic                        cfg_ready,
    output logic [NUM_CH-1:0]           tick,
    output logic [NUM_CH-1:0]           sq
);

    localparam int unsigned CH_W = sel_w(NUM_CH);

    logic              pend_valid;
    logic              pend_valid_nxt_c;
    logic [CH_W-1:0]   pend_ch;
    logic [CNT_W-1:0]  pend_div;
    logic              accept_c;
    logic              ch_ok_c;
    logic [NUM_CH-1:0] load_c;
    logic [NUM_CH-1:0] wrap_c;
    logic [NUM_CH-1:0] idle_c;

    assign accept_c = cfg_valid && cfg_ready;
    assign ch_ok_c  = (32'(cfg_ch) < NUM_CH);

    // Out-of-range requests are consumed without ever occupying the slot.
    always_comb begin
        pend_valid_nxt_c = pend_valid;
        if (accept_c && ch_ok_c) begin
            pend_valid_nxt_c = 1'b1;
        end else if (|load_c) begin
            pend_valid_nxt_c = 1'b0;
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_ch    <= '0;
            pend_div   <= '0;
            cfg_ready  <= 1'b1;
        end else begin
            pend_valid <= pend_valid_nxt_c;
            cfg_ready  <= !pend_valid_nxt_c;
            if (accept_c && ch_ok_c) begin
                pend_ch  <= cfg_ch;
                pend_div <= cfg_div;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load_c[i] = pend_valid && (pend_ch == CH_W'(i))
                         && (wrap_c[i] || idle_c[i] || sync_clr);

        tick_channel #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk_50MHz (clk_50MHz),
            .rst_n     (rst_n),
            .en        (en[i]),
            .sync_clr  (sync_clr),
            .load      (load_c[i]),
            .load_div  (pend_div),
            .wrap_c    (wrap_c[i]),
            .idle_c    (idle_c[i]),
            .tick      (tick[i]),
            .sq        (sq[i])
        );
    end

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator: a 2-channel instance for timing scenarios and
// a 3-channel instance whose 2-bit channel field can address a non-existent channel.
module tb_tick_generator;

    logic       clk_50MHz;
    logic       rst_n;
    logic [1:0] en;
    logic       sync_clr;
    logic       cfg_valid;
    logic [0:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic [1:0] tick;
    logic [1:0] sq;

    logic [2:0] en_b;
    logic       sync_clr_b;
    logic       cfg_valid_b;
    logic [1:0] cfg_ch_b;
    logic [7:0] cfg_div_b;
    logic       cfg_ready_b;
    logic [2:0] tick_b;
    logic [2:0] sq_b;

    int cyc;
    int n_checks;
    int n_pass;

    tick_generator #(
        .NUM_CH   (2),
        .CNT_W    (8),
        .DIV_INIT ({8'd10, 8'd4})
    ) dut (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .en        (en),
        .sync_clr  (sync_clr),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .tick      (tick),
        .sq        (sq)
    );

    tick_generator #(
        .NUM_CH   (3),
        .CNT_W    (8),
        .DIV_INIT ({8'd5, 8'd3, 8'd2})
    ) dut_b (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .en        (en_b),
        .sync_clr  (sync_clr_b),
        .cfg_valid (cfg_valid_b),
        .cfg_ch    (cfg_ch_b),
        .cfg_div   (cfg_div_b),
        .cfg_ready (cfg_ready_b),
        .tick      (tick_b),
        .sq        (sq_b)
    );

    initial clk_50MHz = 1'b0;
    always #10 clk_50MHz = ~clk_50MHz;

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk_50MHz);
        #1;
        cyc++;
    endtask

    task automatic drive_idle();
        en          = 2'b00;
        sync_clr    = 1'b0;
        cfg_valid   = 1'b0;
        cfg_ch      = 1'b0;
        cfg_div     = 8'd0;
        en_b        = 3'b000;
        sync_clr_b  = 1'b0;
        cfg_valid_b = 1'b0;
        cfg_ch_b    = 2'd0;
        cfg_div_b   = 8'd0;
    endtask

    // Leaves the bench 1 time unit after an edge, so the next edge is cycle 1.
    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk_50MHz);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk_50MHz);
        #1;
        n_checks++;
        if (tick !== 2'b00) $display("FAIL reset_tick got=%b exp=00", tick); else n_pass++;
        n_checks++;
        if (sq !== 2'b00) $display("FAIL reset_sq got=%b exp=00", sq); else n_pass++;
        n_checks++;
        if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); else n_pass++;
        n_checks++;
        if (tick_b !== 3'b000) $display("FAIL reset_tick_b got=%b exp=000", tick_b); else n_pass++;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_free_run();
        logic e0, e1, s0, s1;
        do_reset();
        en = 2'b11;
        for (int k = 0; k < 20; k++) begin
            step();
            e0 = (cyc % 4) == 0;
            e1 = (cyc % 10) == 0;
            s0 = ((cyc / 4) % 2) == 1;
            s1 = ((cyc / 10) % 2) == 1;
            n_checks++;
            if (tick[0] !== e0) $display("FAIL free_run_tick0 cyc=%0d got=%b exp=%b", cyc, tick[0], e0); else n_pass++;
            n_checks++;
            if (tick[1] !== e1) $display("FAIL free_run_tick1 cyc=%0d got=%b exp=%b", cyc, tick[1], e1); else n_pass++;
            n_checks++;
            if (sq[0] !== s0) $display("FAIL free_run_sq0 cyc=%0d got=%b exp=%b", cyc, sq[0], s0); else n_pass++;
            n_checks++;
            if (sq[1] !== s1) $display("FAIL free_run_sq1 cyc=%0d got=%b exp=%b", cyc, sq[1], s1); else n_pass++;
        end
    endtask

    task automatic test_cfg_update();
        logic e0, e1, er;
        do_reset();
        en = 2'b11;
        for (int k = 0; k < 22; k++) begin
            if (cyc == 4) begin
                cfg_valid = 1'b1;
                cfg_ch    = 1'b0;
                cfg_div   = 8'd6;
            end
            step();
            cfg_valid = 1'b0;
            e0 = cyc inside {4, 8, 14, 20};
            e1 = (cyc % 10) == 0;
            er = !(cyc >= 5 && cyc <= 7);
            n_checks++;
            if (tick[0] !== e0) $display("FAIL cfg_update_tick0 cyc=%0d got=%b exp=%b", cyc, tick[0], e0); else n_pass++;
            n_checks++;
            if (tick[1] !== e1) $display("FAIL cfg_update_tick1 cyc=%0d got=%b exp=%b", cyc, tick[1], e1); else n_pass++;
            n_checks++;
            if (cfg_ready !== er) $display("FAIL cfg_update_ready cyc=%0d got=%b exp=%b", cyc, cfg_ready, er); else n_pass++;
        end
    endtask

    task automatic test_sync_clr();
        logic e0, e1, s0, s1;
        do_reset();
        en = 2'b11;
        for (int k = 0; k < 20; k++) begin
            if (cyc == 6) sync_clr = 1'b1;
            step();
            sync_clr = 1'b0;
            e0 = cyc inside {4, 11, 15, 19};
            e1 = (cyc == 17);
            s0 = cyc inside {[4:6], [11:14], [19:20]};
            s1 = (cyc >= 17);
            n_checks++;
            if (tick[0] !== e0) $display("FAIL sync_clr_tick0 cyc=%0d got=%b exp=%b", cyc, tick[0], e0); else n_pass++;
            n_checks++;
            if (tick[1] !== e1) $display("FAIL sync_clr_tick1 cyc=%0d got=%b exp=%b", cyc, tick[1], e1); else n_pass++;
            n_checks++;
            if (sq[0] !== s0) $display("FAIL sync_clr_sq0 cyc=%0d got=%b exp=%b", cyc, sq[0], s0); else n_pass++;
            n_checks++;
            if (sq[1] !== s1) $display("FAIL sync_clr_sq1 cyc=%0d got=%b exp=%b", cyc, sq[1], s1); else n_pass++;
        end
    endtask

    task automatic test_enable_gap();
        logic e0, e1, s0;
        do_reset();
        en = 2'b11;
        for (int k = 0; k < 21; k++) begin
            if (cyc == 1) en[0] = 1'b0;
            if (cyc == 5) en[0] = 1'b1;
            step();
            e0 = cyc inside {8, 12, 16, 20};
            e1 = (cyc % 10) == 0;
            s0 = cyc inside {[8:11], [16:19]};
            n_checks++;
            if (tick[0] !== e0) $display("FAIL enable_gap_tick0 cyc=%0d got=%b exp=%b", cyc, tick[0], e0); else n_pass++;
            n_checks++;
            if (tick[1] !== e1) $display("FAIL enable_gap_tick1 cyc=%0d got=%b exp=%b", cyc, tick[1], e1); else n_pass++;
            n_checks++;
            if (sq[0] !== s0) $display("FAIL enable_gap_sq0 cyc=%0d got=%b exp=%b", cyc, sq[0], s0); else n_pass++;
        end
    endtask

    task automatic test_div_limits();
        logic s0;
        do_reset();
        cfg_valid = 1'b1;
        cfg_ch    = 1'b0;
        cfg_div   = 8'd1;
        step();
        cfg_valid = 1'b0;
        n_checks++;
        if (cfg_ready !== 1'b0) $display("FAIL div_limits_ready_busy1 cyc=%0d got=%b exp=0", cyc, cfg_ready); else n_pass++;
        step();
        n_checks++;
        if (cfg_ready !== 1'b1) $display("FAIL div_limits_ready_free1 cyc=%0d got=%b exp=1", cyc, cfg_ready); else n_pass++;
        cfg_valid = 1'b1;
        cfg_ch    = 1'b1;
        cfg_div   = 8'd0;
        step();
        cfg_valid = 1'b0;
        n_checks++;
        if (cfg_ready !== 1'b0) $display("FAIL div_limits_ready_busy2 cyc=%0d got=%b exp=0", cyc, cfg_ready); else n_pass++;
        step();
        n_checks++;
        if (cfg_ready !== 1'b1) $display("FAIL div_limits_ready_free2 cyc=%0d got=%b exp=1", cyc, cfg_ready); else n_pass++;
        en = 2'b11;
        for (int k = 0; k < 8; k++) begin
            step();
            s0 = ((cyc - 4) % 2) == 1;
            n_checks++;
            if (tick[0] !== 1'b1) $display("FAIL div1_tick0 cyc=%0d got=%b exp=1", cyc, tick[0]); else n_pass++;
            n_checks++;
            if (tick[1] !== 1'b0) $display("FAIL div0_tick1 cyc=%0d got=%b exp=0", cyc, tick[1]); else n_pass++;
            n_checks++;
            if (sq[0] !== s0) $display("FAIL div1_sq0 cyc=%0d got=%b exp=%b", cyc, sq[0], s0); else n_pass++;
            n_checks++;
            if (sq[1] !== 1'b0) $display("FAIL div0_sq1 cyc=%0d got=%b exp=0", cyc, sq[1]); else n_pass++;
        end
    endtask

    task automatic test_bad_ch();
        logic [2:0] eb;
        do_reset();
        en_b        = 3'b111;
        cfg_valid_b = 1'b1;
        cfg_ch_b    = 2'd3;
        cfg_div_b   = 8'd1;
        for (int k = 0; k < 12; k++) begin
            step();
            cfg_valid_b = 1'b0;
            eb = {(cyc % 5) == 0, (cyc % 3) == 0, (cyc % 2) == 0};
            n_checks++;
            if (tick_b !== eb) $display("FAIL bad_ch_tick cyc=%0d got=%b exp=%b", cyc, tick_b, eb); else n_pass++;
        end
        n_checks++;
        if (cfg_ready_b !== 1'b1) $display("FAIL bad_ch_ready cyc=%0d got=%b exp=1", cyc, cfg_ready_b); else n_pass++;
    endtask

    task automatic test_reset_pending();
        logic e0, e1;
        do_reset();
        en = 2'b11;
        for (int k = 0; k < 6; k++) begin
            if (cyc == 4) begin
                cfg_valid = 1'b1;
                cfg_ch    = 1'b0;
                cfg_div   = 8'd6;
            end
            step();
            cfg_valid = 1'b0;
        end
        n_checks++;
        if (cfg_ready !== 1'b0) $display("FAIL rst_pend_busy cyc=%0d got=%b exp=0", cyc, cfg_ready); else n_pass++;
        n_checks++;
        if (sq[0] !== 1'b1) $display("FAIL rst_pend_sq_before cyc=%0d got=%b exp=1", cyc, sq[0]); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tick !== 2'b00) $display("FAIL rst_pend_tick got=%b exp=00", tick); else n_pass++;
        n_checks++;
        if (sq !== 2'b00) $display("FAIL rst_pend_sq got=%b exp=00", sq); else n_pass++;
        n_checks++;
        if (cfg_ready !== 1'b1) $display("FAIL rst_pend_ready got=%b exp=1", cfg_ready); else n_pass++;
        @(posedge clk_50MHz);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            e0 = (cyc % 4) == 0;
            e1 = (cyc == 10);
            n_checks++;
            if (tick[0] !== e0) $display("FAIL rst_pend_tick0 cyc=%0d got=%b exp=%b", cyc, tick[0], e0); else n_pass++;
            n_checks++;
            if (tick[1] !== e1) $display("FAIL rst_pend_tick1 cyc=%0d got=%b exp=%b", cyc, tick[1], e1); else n_pass++;
            n_checks++;
            if (cfg_ready !== 1'b1) $display("FAIL rst_pend_ready_after cyc=%0d got=%b exp=1", cyc, cfg_ready); else n_pass++;
        end
    endtask

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_free_run();
        test_cfg_update();
        test_sync_clr();
        test_enable_gap();
        test_div_limits();
        test_bad_ch();
        test_reset_pending();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
